// File: rtl/lcd_timing_pkg.sv
// Timing constants and colour helpers for the 480x272 RGB LCD scan-out.
package lcd_timing_pkg;
  localparam int H_VIS   = 480;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 41;
  localparam int H_BP    = 2;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 272;
  localparam int V_FP    = 2;
  localparam int V_SYNC  = 10;
  localparam int V_BP    = 2;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int DISP_WIDTH = 480;
  localparam int RADDR_MAX  = 130559;
  localparam int ADDR_W     = 17;
  localparam int CNT_W      = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // RGB565 (B in the top bits) to RGB888 by MSB replication.
  function automatic rgb_t expand565(input logic [15:0] px);
    rgb_t c;
    c.r = {px[4:0], px[4:2]};
    c.g = {px[10:5], px[10:9]};
    c.b = {px[15:11], px[15:13]};
    return c;
  endfunction
endpackage

// File: rtl/lcd_timing_gen.sv
// Phase/h/v counters for the LCD raster; one pixel slot is four clocks.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_VIS_N  = H_VIS,
  parameter int H_FP_N   = H_FP,
  parameter int H_SYNC_N = H_SYNC,
  parameter int H_BP_N   = H_BP,
  parameter int V_VIS_N  = V_VIS,
  parameter int V_FP_N   = V_FP,
  parameter int V_SYNC_N = V_SYNC,
  parameter int V_BP_N   = V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             tick,
  output logic             visible,
  output logic             hsync_rgn,
  output logic             vsync_rgn,
  output logic             frame_wrap
);
  localparam int H_TOT = H_VIS_N + H_FP_N + H_SYNC_N + H_BP_N;
  localparam int V_TOT = V_VIS_N + V_FP_N + V_SYNC_N + V_BP_N;
  localparam int HS_LO = H_VIS_N + H_FP_N;
  localparam int VS_LO = V_VIS_N + V_FP_N;

  logic h_last, v_last;

  assign tick   = phase == 2'd3;
  assign h_last = h == CNT_W'(H_TOT - 1);
  assign v_last = v == CNT_W'(V_TOT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 2'd0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (tick) begin
        h <= h_last ? '0 : h + CNT_W'(1);
        if (h_last) v <= v_last ? '0 : v + CNT_W'(1);
      end
    end
  end

  assign visible    = (h < CNT_W'(H_VIS_N)) && (v < CNT_W'(V_VIS_N));
  assign hsync_rgn  = (h >= CNT_W'(HS_LO)) && (h < CNT_W'(HS_LO + H_SYNC_N));
  assign vsync_rgn  = (v >= CNT_W'(VS_LO)) && (v < CNT_W'(VS_LO + V_SYNC_N));
  assign frame_wrap = tick && h_last && v_last;
endmodule

// File: rtl/lcd_scan_reader.sv
// Reads the frame buffer from SRAM in raster order and drives a parallel RGB LCD.
module lcd_scan_reader
  import lcd_timing_pkg::*;
#(
  parameter int H_VIS_N  = H_VIS,
  parameter int H_FP_N   = H_FP,
  parameter int H_SYNC_N = H_SYNC,
  parameter int H_BP_N   = H_BP,
  parameter int V_VIS_N  = V_VIS,
  parameter int V_FP_N   = V_FP,
  parameter int V_SYNC_N = V_SYNC,
  parameter int V_BP_N   = V_BP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dispOn,
  input  logic        i_height_is_270,
  input  logic [23:0] i_sram_rdata,
  output logic [16:0] o_sram_raddr,
  output logic [16:0] o_sram_raddr_max,
  output logic [15:0] o_disp_width,
  output logic        o_lcd_dclk,
  output logic        o_lcd_hsync,
  output logic        o_lcd_vsync,
  output logic        o_lcd_de,
  output logic [7:0]  o_lcd_r,
  output logic [7:0]  o_lcd_g,
  output logic [7:0]  o_lcd_b,
  output logic        o_frame_start
);
  localparam int H_TOT = H_VIS_N + H_FP_N + H_SYNC_N + H_BP_N;

  logic [1:0]       phase;
  logic [CNT_W-1:0] h, v;
  logic             tick, visible, hsync_rgn, vsync_rgn, frame_wrap;
  logic             border, blank, addr_step;
  logic             unused_rdata_hi;
  rgb_t             px;

  lcd_timing_gen #(
    .H_VIS_N(H_VIS_N), .H_FP_N(H_FP_N), .H_SYNC_N(H_SYNC_N), .H_BP_N(H_BP_N),
    .V_VIS_N(V_VIS_N), .V_FP_N(V_FP_N), .V_SYNC_N(V_SYNC_N), .V_BP_N(V_BP_N)
  ) u_timing (
    .clk(i_clk), .rst(i_rst), .phase(phase), .h(h), .v(v), .tick(tick),
    .visible(visible), .hsync_rgn(hsync_rgn), .vsync_rgn(vsync_rgn),
    .frame_wrap(frame_wrap)
  );

  assign o_sram_raddr_max = ADDR_W'(RADDR_MAX);
  assign o_disp_width     = 16'(DISP_WIDTH);
  assign unused_rdata_hi  = ^i_sram_rdata[23:16];

  assign px     = expand565(i_sram_rdata[15:0]);
  assign border = (v == '0) || (v == CNT_W'(V_VIS_N - 1));
  assign blank  = !visible || !i_dispOn || (i_height_is_270 && border);

  // The address parks on a line's last pixel through h-blanking and steps into
  // the next row at the line wrap, so it never runs past the final pixel.
  assign addr_step = (visible && (h != CNT_W'(H_VIS_N - 1))) ||
                     ((h == CNT_W'(H_TOT - 1)) && (v < CNT_W'(V_VIS_N - 1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sram_raddr  <= '0;
      o_lcd_dclk    <= 1'b0;
      o_lcd_hsync   <= 1'b1;
      o_lcd_vsync   <= 1'b1;
      o_lcd_de      <= 1'b0;
      o_lcd_r       <= '0;
      o_lcd_g       <= '0;
      o_lcd_b       <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_lcd_dclk    <= (phase == 2'd1) || (phase == 2'd2);
      o_frame_start <= frame_wrap;
      if (tick) begin
        o_lcd_de    <= visible;
        o_lcd_hsync <= ~hsync_rgn;
        o_lcd_vsync <= ~vsync_rgn;
        {o_lcd_r, o_lcd_g, o_lcd_b} <= blank ? 24'h0 : px;
        if (frame_wrap)     o_sram_raddr <= '0;
        else if (addr_step) o_sram_raddr <= o_sram_raddr + 17'd1;
      end
    end
  end
endmodule
